// File: rtl/fpu_mul_arb.sv
// Round-robin front end for one shared, fully pipelined fpu_mul.
// Up to N requesters hand over operand pairs with a valid/grant handshake.
// At most one pair is issued per cycle. A tag pipe carries each requester ID
// alongside the multiplier, so each result is steered back to the requester
// that issued it.
module fpu_mul_arb #(
    parameter int unsigned N   = 4,
    parameter int unsigned LAT = 3,
    parameter int unsigned IDW = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [N-1:0]      REQ,
    input  logic [N*32-1:0]   REQ_A,
    input  logic [N*32-1:0]   REQ_B,
    output logic [N-1:0]      GNT,
    output logic [N-1:0]      RSP_VALID,
    output logic [31:0]       RSP_Z,
    output logic              MUL_EN,
    output logic [31:0]       MUL_A,
    output logic [31:0]       MUL_B,
    input  logic [31:0]       MUL_Z,
    output logic              BUSY,
    output logic [IDW+1:0]    INFLIGHT
);

    // Stage 0 lines up with the MUL_A/MUL_B register. The remaining LAT stages
    // track the multiplier, so the last stage coincides with a valid MUL_Z.
    localparam int unsigned Depth = LAT + 1;

    logic [IDW-1:0]   rr_ptr_q;
    logic             mul_en_q;
    logic [31:0]      mul_a_q, mul_b_q;
    logic [Depth-1:0] tag_vld_q;
    logic [IDW-1:0]   tag_id_q [Depth];
    logic [IDW+1:0]   inflight_q, inflight_d;

    logic [IDW-1:0]   gnt_id;
    logic             found;
    logic [31:0]      scan_idx;
    logic             xfer;

    // Rotating priority scan starting just after the last granted requester.
    always_comb begin
        gnt_id   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % N;
            if (!found && REQ[scan_idx[IDW-1:0]]) begin
                found  = 1'b1;
                gnt_id = scan_idx[IDW-1:0];
            end
        end
    end

    // Grant is held off during reset and in the first cycle after reset.
    // That cycle is marked by mul_en_q still being low.
    always_comb begin
        GNT = '0;
        if (RESET_N && mul_en_q && found) begin
            GNT[gnt_id] = 1'b1;
        end
    end

    assign xfer = |GNT;

    // In-flight counter: a transfer and a retirement in the same cycle cancel.
    always_comb begin
        inflight_d = inflight_q;
        case ({xfer, tag_vld_q[Depth-1]})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // Control state, operand registers and tag valid pipe.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            rr_ptr_q   <= IDW'(N - 1);
            mul_en_q   <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            tag_vld_q  <= '0;
            inflight_q <= '0;
        end else begin
            mul_en_q   <= 1'b1;
            tag_vld_q  <= {tag_vld_q[Depth-2:0], xfer};
            inflight_q <= inflight_d;
            if (xfer) begin
                rr_ptr_q <= gnt_id;
                mul_a_q  <= REQ_A[32'(gnt_id)*32 +: 32];
                mul_b_q  <= REQ_B[32'(gnt_id)*32 +: 32];
            end
        end
    end

    // Tag IDs carry no reset: they only matter where the matching valid bit is set.
    always_ff @(posedge CLK) begin
        tag_id_q[0] <= gnt_id;
        for (int unsigned i = 1; i < Depth; i++) begin
            tag_id_q[i] <= tag_id_q[i-1];
        end
    end

    // Steer the multiplier result to the requester that issued it.
    always_comb begin
        RSP_VALID = '0;
        if (RESET_N && tag_vld_q[Depth-1]) begin
            RSP_VALID[tag_id_q[Depth-1]] = 1'b1;
        end
    end

    assign RSP_Z    = MUL_Z;
    assign MUL_EN   = mul_en_q;
    assign MUL_A    = mul_a_q;
    assign MUL_B    = mul_b_q;
    assign INFLIGHT = inflight_q;
    assign BUSY     = RESET_N && (inflight_q != '0);

endmodule
